rc_step_sequencer: RTL
======================

// Module: rc_step_sequencer
//
// PURPOSE
//   Drives the v_in port of rc_model with a repeated rising/falling step pattern.
//   Monitors v_out for settling within a tolerance band and for exceeding an
//   absolute limit. Reports pass/fail, an error code and the worst-case settle
//   time. Sits between the test wrapper and rc_model, and replaces the constant
//   stimulus plus free-running assertion with a sequenced, self-checking run.
//
// PARAMETERS
//   `DECL_REAL(v_in)    -        svreal format of the driven v_in output
//   `DECL_REAL(v_out)   -        svreal format of the monitored v_out input
//   V_HIGH              1.0      high step level (real)
//   V_LOW               0.0      low step level (real)
//   V_LIMIT             2.0      absolute limit; v_out >= V_LIMIT is an error
//   TOL                 0.05     settle band half-width around the target
//   HOLD_CYCLES         1000     cycles each step level is held (2..2**CNT_W-1)
//   N_STEPS             4        rise/fall pairs per run (>=1)
//   CNT_W               16       width of hold counter and settle_cycles
//
// PORTS
//   clk            in   1              system clock
//   rst            in   1              asynchronous reset, active-high
//   start          in   1              run request; sampled only in IDLE/DONE
//   v_out          in   real(v_out)    rc_model output being checked
//   v_in           out  real(v_in)     registered stimulus to rc_model
//   busy           out  1              high in RISE/FALL
//   done           out  1              high in DONE until the next start
//   pass           out  1              valid when done=1; 1 = all checks met
//   err_code       out  2              0 none, 1 no-settle timeout, 2 overlimit
//   step_idx       out  $clog2(N_STEPS)+1   index of current rise/fall pair
//   settle_cycles  out  CNT_W          max first-in-band hold count over all edges
//
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, v_in=V_LOW, busy=0, done=0, pass=0,
//     err_code=0, step_idx=0, settle_cycles=0, hold_cnt=0, settled=0.
//   - States: IDLE, RISE, FALL, DONE. All outputs are registered.
//   - IDLE/DONE + start=1 -> RISE. Clears done, pass, err_code, step_idx,
//     settle_cycles, hold_cnt and settled. v_in=V_HIGH from the next cycle
//     (1-cycle latency).
//   - RISE: v_in=V_HIGH, target=V_HIGH. FALL: v_in=V_LOW, target=V_LOW.
//     hold_cnt counts 0..HOLD_CYCLES-1 and resets to 0 on each state entry.
//   - In-band: (target-TOL) < v_out < (target+TOL), strict, computed in the
//     v_out format. On the first in-band cycle of a level: settled=1 and
//     settle_cycles = max(settle_cycles, hold_cnt). Later band exits are ignored.
//   - Overlimit: any RISE/FALL cycle with v_out >= V_LIMIT goes to DONE on the
//     next edge with err_code=2, pass=0, v_in=V_LOW. Overlimit beats timeout
//     when both occur in the same cycle.
//   - End of level (hold_cnt==HOLD_CYCLES-1), settled=0: DONE, err_code=1,
//     pass=0, v_in=V_LOW.
//   - End of level, settled=1:
//     - RISE -> FALL.
//     - FALL with step_idx < N_STEPS-1 -> RISE and step_idx+1.
//     - FALL with step_idx == N_STEPS-1 -> DONE with pass=1, err_code=0.
//   - DONE: busy=0, done=1, v_in=V_LOW. Outputs hold until start.
//   - start while busy is ignored (no restart, no effect).
//   - A successful run takes 2*N_STEPS*HOLD_CYCLES cycles from the first
//     V_HIGH cycle to done=1.
//   - All real comparisons and constants use svreal macros. Real widths follow
//     the declared formats. hold_cnt never wraps, because HOLD_CYCLES < 2**CNT_W.
//
// TESTING
//   1. rc_model with tau << hold (HOLD_CYCLES=200, N_STEPS=2), 1-cycle start ->
//      v_in pattern 1.0/0.0/1.0/0.0, 200 cycles each; done=1 at cycle 801;
//      pass=1, err_code=0, 0 < settle_cycles < 200.
//   2. Stub v_out held at 0.5, HOLD_CYCLES=200 -> at the end of the first RISE:
//      done=1, err_code=1, pass=0, v_in=0.0, step_idx=0.
//   3. Stub v_out forced to 2.5 at cycle 50 of the first FALL -> next edge:
//      done=1, err_code=2, v_in=0.0. Also force 2.5 on the last hold cycle of a
//      never-settled level -> err_code=2, not 1.
//   4. start pulsed at cycle 10 of RISE -> ignored, same timing as test 1.
//      start in DONE -> restarts: done=0, err_code=0, v_in=1.0 on the next cycle.
//   5. rst asserted mid-FALL between clock edges -> all outputs reach reset
//      values with no clock edge. After release, the block stays IDLE until start.
//   6. v_out enters the band at hold_cnt=37 (rise) and 52 (fall), then leaves
//      it -> no error; settle_cycles=52.

Source files
------------

// File: rtl/rc_step_sequencer.sv
// rtl/rc_step_sequencer.sv - step stimulus sequencer with settle/overlimit checking for rc_model
//
// Drives v_in with repeated high/low step levels and checks v_out against a
// settle band around the current target and an absolute upper limit.
// Real quantities are signed fixed point: value = code * 2**EXP.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   start          in   run request, sampled only in IDLE/DONE
//   v_out          in   monitored rc_model output (OUT_W, OUT_EXP format)
//   v_in           out  registered stimulus (IN_W, IN_EXP format)
//   busy           out  high while stepping (RISE/FALL)
//   done           out  high in DONE until the next start
//   pass           out  1 = run completed with every level settled
//   err_code       out  0 none, 1 no-settle timeout, 2 overlimit
//   step_idx       out  index of the current rise/fall pair
//   settle_cycles  out  worst first-in-band hold count over all levels
module rc_step_sequencer #(
    parameter int  IN_W        = 18,
    parameter int  IN_EXP      = -12,
    parameter int  OUT_W       = 18,
    parameter int  OUT_EXP     = -12,
    parameter real V_HIGH      = 1.0,
    parameter real V_LOW       = 0.0,
    parameter real V_LIMIT     = 2.0,
    parameter real TOL         = 0.05,
    parameter int  HOLD_CYCLES = 1000,
    parameter int  N_STEPS     = 4,
    parameter int  CNT_W       = 16,
    localparam int STEP_W      = $clog2(N_STEPS) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [OUT_W-1:0] v_out,
    output logic signed [IN_W-1:0]  v_in,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [1:0]              err_code,
    output logic [STEP_W-1:0]       step_idx,
    output logic [CNT_W-1:0]        settle_cycles
);

    // Two guard bits so target +/- TOL cannot overflow the compare.
    localparam int CW = OUT_W + 2;

    localparam real IN_SCALE  = 2.0 ** (-IN_EXP);
    localparam real OUT_SCALE = 2.0 ** (-OUT_EXP);

    localparam logic signed [IN_W-1:0] HIGH_IN = IN_W'($rtoi(V_HIGH * IN_SCALE));
    localparam logic signed [IN_W-1:0] LOW_IN  = IN_W'($rtoi(V_LOW * IN_SCALE));

    localparam logic signed [CW-1:0] HIGH_O  = CW'($rtoi(V_HIGH * OUT_SCALE));
    localparam logic signed [CW-1:0] LOW_O   = CW'($rtoi(V_LOW * OUT_SCALE));
    localparam logic signed [CW-1:0] LIMIT_O = CW'($rtoi(V_LIMIT * OUT_SCALE));
    localparam logic signed [CW-1:0] TOL_O   = CW'($rtoi(TOL * OUT_SCALE));

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_LIMIT   = 2'd2;

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state, state_n;
    logic signed [IN_W-1:0]   v_in_n;
    logic                     busy_n, done_n, pass_n;
    logic [1:0]               err_code_n;
    logic [STEP_W-1:0]        step_idx_n;
    logic [CNT_W-1:0]         settle_cycles_n;
    logic [CNT_W-1:0]         hold_cnt, hold_cnt_n;
    logic                     settled, settled_n;

    logic signed [CW-1:0]     vo_ext;
    logic signed [CW-1:0]     target;
    logic                     in_band;
    logic                     over_limit;
    logic                     level_end;
    logic                     settled_now;

    assign vo_ext     = {{2{v_out[OUT_W-1]}}, v_out};
    assign target     = (state == FALL) ? LOW_O : HIGH_O;
    assign in_band    = (vo_ext > (target - TOL_O)) && (vo_ext < (target + TOL_O));
    assign over_limit = (vo_ext >= LIMIT_O);
    assign level_end  = (hold_cnt == HOLD_LAST);
    // A level whose first in-band cycle is its last hold cycle still counts as settled.
    assign settled_now = settled || in_band;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            v_in          <= LOW_IN;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_code      <= ERR_NONE;
            step_idx      <= '0;
            settle_cycles <= '0;
            hold_cnt      <= '0;
            settled       <= 1'b0;
        end else begin
            state         <= state_n;
            v_in          <= v_in_n;
            busy          <= busy_n;
            done          <= done_n;
            pass          <= pass_n;
            err_code      <= err_code_n;
            step_idx      <= step_idx_n;
            settle_cycles <= settle_cycles_n;
            hold_cnt      <= hold_cnt_n;
            settled       <= settled_n;
        end
    end

    always_comb begin
        state_n         = state;
        v_in_n          = v_in;
        busy_n          = busy;
        done_n          = done;
        pass_n          = pass;
        err_code_n      = err_code;
        step_idx_n      = step_idx;
        settle_cycles_n = settle_cycles;
        hold_cnt_n      = hold_cnt;
        settled_n       = settled;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n         = RISE;
                    v_in_n          = HIGH_IN;
                    busy_n          = 1'b1;
                    done_n          = 1'b0;
                    pass_n          = 1'b0;
                    err_code_n      = ERR_NONE;
                    step_idx_n      = '0;
                    settle_cycles_n = '0;
                    hold_cnt_n      = '0;
                    settled_n       = 1'b0;
                end
            end

            RISE, FALL: begin
                hold_cnt_n = hold_cnt + 1'b1;

                // Only the first in-band cycle of a level is recorded.
                if (in_band && !settled) begin
                    settled_n = 1'b1;
                    if (hold_cnt > settle_cycles)
                        settle_cycles_n = hold_cnt;
                end

                if (over_limit) begin
                    state_n    = DONE;
                    v_in_n     = LOW_IN;
                    busy_n     = 1'b0;
                    done_n     = 1'b1;
                    pass_n     = 1'b0;
                    err_code_n = ERR_LIMIT;
                    hold_cnt_n = '0;
                end else if (level_end) begin
                    hold_cnt_n = '0;
                    settled_n  = 1'b0;
                    if (!settled_now) begin
                        state_n    = DONE;
                        v_in_n     = LOW_IN;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                        pass_n     = 1'b0;
                        err_code_n = ERR_TIMEOUT;
                    end else if (state == RISE) begin
                        state_n = FALL;
                        v_in_n  = LOW_IN;
                    end else if (step_idx != STEP_LAST) begin
                        state_n    = RISE;
                        v_in_n     = HIGH_IN;
                        step_idx_n = step_idx + 1'b1;
                    end else begin
                        state_n    = DONE;
                        v_in_n     = LOW_IN;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                        pass_n     = 1'b1;
                        err_code_n = ERR_NONE;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule
